// File: rtl/muldiv_if.sv
// Request / writeback bundle between the issuing pipeline and the
// multiply/divide unit. The pipeline side is the master; the unit is the slave.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            done;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output start, funct3, rd, rs1_data, rs2_data,
    input  busy, done, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  start, funct3, rd, rs1_data, rs2_data,
    output busy, done, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply
// and restoring divide on operand magnitudes, sign fix-up in a final cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish after a
// single CALC cycle. All outputs come straight from registers.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_b;       // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;      // multiplier bits / dividend bits -> quotient
  logic              r_neg_q;   // negate product or quotient at the end
  logic              r_neg_r;   // negate remainder at the end
  logic [5:0]        r_cnt;
  logic              r_last;    // iteration finished, next CALC edge finalises
  logic              r_busy;
  logic              r_done;
  logic              r_wb_we;
  logic [4:0]        r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;

  // Operand decode for the incoming request
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_overflow;

  // One iteration step and the final result
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rs;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wb_we   = r_wb_we;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;

  // Signedness, magnitudes and special cases of the request on the bus
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch
    // is inferred.
    w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);
    w_a_neg    = w_a_signed && bus.rs1_data[XLEN-1];
    w_b_neg    = w_b_signed && bus.rs2_data[XLEN-1];
    w_a_mag    = w_a_neg ? -bus.rs1_data : bus.rs1_data;
    w_b_mag    = w_b_neg ? -bus.rs2_data : bus.rs2_data;
    w_div_zero = bus.funct3[2] && (bus.rs2_data == '0);
    w_overflow = bus.funct3[2] && !bus.funct3[0] &&
                 (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.rs2_data == '1);
  end

  // Next partial state for one multiply or divide step
  always_comb begin
    w_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    w_rs   = {r_hi, r_lo[XLEN-1]};
    w_ge   = (w_rs >= {1'b0, r_b});
    // The trial difference is below the divisor whenever it is kept, so the
    // low XLEN bits are exact.
    w_diff = w_rs[XLEN-1:0] - r_b;
    if (r_funct3[2]) begin
      w_hi_nxt = w_ge ? w_diff : w_rs[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the finished iteration
  always_comb begin
    w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo  = r_neg_q ? -r_lo : r_lo;
    w_rem  = r_neg_r ? -r_hi : r_hi;
    case (r_funct3)
      3'b000:                w_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        w_result = w_quo;
      default:               w_result = w_rem;
    endcase
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, operands included,
    // so an aborted operation leaves nothing behind.
    if (!rst) begin
      r_state   <= S_IDLE;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register here sees the
      // values from before this edge.
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_funct3 <= bus.funct3;
            r_rd     <= bus.rd;
            r_cnt    <= '0;
            r_b      <= bus.funct3[2] ? w_b_mag : w_a_mag;
            if (w_div_zero) begin
              // Preload the architectural result; finalisation passes it through.
              r_hi    <= bus.rs1_data;
              r_lo    <= '1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_last  <= 1'b1;
            end else if (w_overflow) begin
              r_hi    <= '0;
              r_lo    <= {1'b1, {(XLEN-1){1'b0}}};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_last  <= 1'b1;
            end else begin
              r_hi    <= '0;
              r_lo    <= bus.funct3[2] ? w_a_mag : w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_last  <= 1'b0;
            end
          end
        end

        S_CALC: begin
          if (r_last) begin
            r_state   <= S_DONE;
            r_last    <= 1'b0;
            r_done    <= 1'b1;
            r_wb_we   <= (r_rd != 5'd0);
            r_wb_addr <= r_rd;
            r_wb_data <= w_result;
          end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == 6'd31) begin
              r_last <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wb_we <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, hand-written sequences for
// busy-start, back-to-back and mid-operation reset, then randomized operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M result from plain 64-bit / int arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    int          ia;
    int          ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, scramble inputs after acceptance, optionally pulse
  // start during CALC and DONE, then check latency, writeback and hold.
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit poke, input string name);
    int n;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rd       = rd;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(posedge clk);
    #1;
    check({name, " busy after accept"}, 32'(bus.busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (n == 0) begin
        bus.funct3   = 3'($urandom);
        bus.rd       = 5'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
      end
      bus.start = (poke && n == 10);
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " wb_data"}, bus.wb_data, exp);
    check({name, " wb_we"}, 32'(bus.wb_we), 32'(rd != 5'd0));
    check({name, " wb_addr"}, 32'(bus.wb_addr), 32'(rd));
    check({name, " busy in done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = poke;
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, 32'(bus.done), 32'd0);
    check({name, " wb_we one cycle"}, 32'(bus.wb_we), 32'd0);
    check({name, " idle after done"}, 32'(bus.busy), 32'd0);
    check({name, " wb_data held"}, bus.wb_data, exp);
    check({name, " wb_addr held"}, 32'(bus.wb_addr), 32'(rd));
  endtask

  initial begin
    int dones;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;

    tbl[0]  = '{3'b000, 5'd5,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'b001, 5'd6,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    tbl[2]  = '{3'b011, 5'd7,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'b010, 5'd8,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'b010, 5'd9,  32'd2,          32'hFFFF_FFFF, 32'h0000_0001, 33};
    tbl[5]  = '{3'b100, 5'd10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    tbl[6]  = '{3'b110, 5'd11, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    tbl[7]  = '{3'b101, 5'd12, 32'd100,        32'd7,         32'd14,        33};
    tbl[8]  = '{3'b111, 5'd13, 32'd100,        32'd7,         32'd2,         33};
    tbl[9]  = '{3'b101, 5'd14, 32'd13,         32'd0,         32'hFFFF_FFFF, 1};
    tbl[10] = '{3'b111, 5'd15, 32'd13,         32'd0,         32'd13,        1};
    tbl[11] = '{3'b100, 5'd16, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[12] = '{3'b110, 5'd17, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[13] = '{3'b110, 5'd31, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};
    tbl[14] = '{3'b000, 5'd0,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};

    bus.start    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rd       = 5'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset wb_we", 32'(bus.wb_we), 32'd0);
    check("reset wb_addr", 32'(bus.wb_addr), 32'd0);
    check("reset wb_data", bus.wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].f3, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b0,
             $sformatf("vec%0d", i));
    end

    // start pulsed in CALC and DONE is ignored; start held into the cycle
    // after done is accepted as the next operation
    run_op(3'b000, 5'd3, 32'd3, 32'd5, 32'd15, 33, 1'b1, "busy start ignored");
    run_op(3'b101, 5'd4, 32'd100, 32'd7, 32'd14, 33, 1'b0, "start after done");

    // Reset ten cycles into CALC aborts with no done and no write
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = 3'b000;
    bus.rd       = 5'd9;
    bus.rs1_data = 32'd123;
    bus.rs2_data = 32'd456;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort wb_we", 32'(bus.wb_we), 32'd0);
    check("abort wb_data", bus.wb_data, 32'd0);
    check("abort wb_addr", 32'(bus.wb_addr), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("start in reset ignored", 32'(bus.busy), 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.wb_we) dones++;
    end
    check("no completion after abort", 32'(dones), 32'd0);
    run_op(3'b101, 5'd2, 32'd9, 32'd3, 32'd3, 33, 1'b0, "divu after abort");

    // Randomized operations against the reference model
    for (int i = 0; i < 50; i++) begin
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom);
      a  = rnd_val();
      b  = rnd_val();
      run_op(f3, rd, a, b, ref_result(f3, a, b), ref_latency(f3, a, b), 1'b0,
             $sformatf("rand%0d f3=%0d a=%08h b=%08h", i, f3, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rd  input  5  destination register index.
REQ-007 SHALL have port rs1_data  input  32  operand A (multiplicand/dividend).
REQ-008 SHALL have port rs2_data  input  32  operand B (multiplier/divisor).
REQ-009 SHALL have port busy  output  1  high in CALC and DONE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port wb_we  output  1  register-file write enable.
REQ-012 SHALL have port wb_addr  output  5  register-file write address.
REQ-013 SHALL have port wb_data  output  32  register-file write data.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; all outputs registered.
REQ-015 In IDLE with start=1 at edge k, SHALL latch funct3, rd, operands; convert to magnitudes per signedness (MULH/DIV/REM: both signed; MULHSU: A signed, B unsigned; MULHU/DIVU/REMU/MUL: unsigned); record result sign.
REQ-016 Normal ops SHALL go IDLE->CALC, process one bit per cycle for exactly 32 cycles (shift-add multiply into 64-bit product; restoring divide), then enter DONE at edge k+33.
REQ-017 Divide-by-zero (B=0, ops 1xx) SHALL go IDLE->DONE at edge k+1: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU remainder = A.
REQ-018 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF) SHALL go IDLE->DONE at edge k+1: DIV 0x80000000, REM 0.
REQ-019 Sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-020 Result selection: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-021 DONE SHALL last exactly one cycle: done=1, wb_addr=latched rd, wb_data=result, wb_we=1 unless rd=0 (then wb_we=0, done still 1); next edge -> IDLE.
REQ-022 start while busy=1 (CALC or DONE) SHALL be ignored; earliest accepted start is the cycle after done.
REQ-023 Operand/funct3/rd input changes after edge k SHALL not affect the in-flight result.
REQ-024 wb_data and wb_addr SHALL hold last values outside DONE; wb_we and done SHALL be 0 outside DONE.
REQ-025 Iteration counter SHALL be 6 bits, count 0..31, no wrap beyond 31.

Reset
REQ-026 rst=0 at any edge SHALL force IDLE; busy, done, wb_we = 0; wb_addr = 0; wb_data = 0; counter and operand registers = 0.
REQ-027 Reset during CALC or DONE SHALL abort: no done pulse, no write.
REQ-028 start sampled in a cycle with rst=0 SHALL be ignored.

Verification
REQ-029 MUL A=7, B=0xFFFFFFFD, rd=5 -> done at k+33, wb_we=1, wb_addr=5, wb_data=0xFFFFFFEB; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all at k+33.
REQ-031 DIVU 13/0 -> 0xFFFFFFFF, REMU 13/0 -> 13, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; each done at k+1.
REQ-032 MUL with rd=0 -> done=1 at k+33, wb_we=0; start pulsed during CALC and DONE -> no extra operation; start the cycle after done -> accepted.
REQ-033 rst=0 asserted 10 cycles into CALC -> busy=0 after that edge, no done/wb_we; subsequent DIVU 9/3 -> 3 at its own k+33.
